otter_btb: RTL and testbench
============================

OTTER_BTB -- requirements
Module: otter_btb

Interface
REQ-001 Parameter ENTRIES, default 16, number of direct-mapped entries; power of two, 2..256.
REQ-002 Parameter XLEN, default 32, PC and target width.
REQ-003 CLK  input  1  single clock; all state updates on posedge.
REQ-004 RST  input  1  synchronous, active-high reset.
REQ-005 LKP_PC  input  XLEN  fetch-stage PC to predict.
REQ-006 PRED_TAKEN  output  1  predict redirect for LKP_PC.
REQ-007 PRED_TARGET  output  XLEN  predicted next PC when PRED_TAKEN=1, else LKP_PC+4.
REQ-008 UPD_EN  input  1  execute-stage resolution valid this cycle (branch or jump only).
REQ-009 UPD_PC  input  XLEN  PC of the resolved control instruction.
REQ-010 UPD_TAKEN  input  1  resolved direction.
REQ-011 UPD_TARGET  input  XLEN  resolved target address.
REQ-012 UPD_JUMP  input  1  resolved instruction is JAL/JALR (unconditional).
REQ-013 INVALIDATE  input  1  clear all entries (fence.i / self-modifying code).

Function
REQ-014 Index = PC[IDX_W+1:2], IDX_W = log2(ENTRIES); tag = PC[XLEN-1:IDX_W+2]; PC[1:0] ignored.
REQ-015 Each entry holds: valid, tag, XLEN-bit target, 2-bit counter (00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T).
REQ-016 Lookup combinational, zero latency: hit = valid && tag match; PRED_TAKEN = hit && ctr[1].
REQ-017 PRED_TARGET = stored target on PRED_TAKEN, else LKP_PC+4 (modulo 2^XLEN, wraps at top of address space).
REQ-018 Updates take effect at the posedge where UPD_EN=1; visible to lookups from the next cycle.
REQ-019 Same-cycle lookup and update to same index: lookup returns pre-update contents (no bypass).
REQ-020 Update, hit, UPD_JUMP=1: ctr <= 11, target <= UPD_TARGET.
REQ-021 Update, hit, conditional: taken -> ctr+1 saturating at 11, target <= UPD_TARGET; not-taken -> ctr-1 saturating at 00, target unchanged.
REQ-022 Update, miss, taken (or jump): allocate/replace entry: valid <= 1, tag, target <= UPD_TARGET, ctr <= 10 (11 if UPD_JUMP).
REQ-023 Update, miss, not taken: no change to any entry.
REQ-024 UPD_EN=0: all entry state held; UPD_* inputs ignored.
REQ-025 INVALIDATE=1: all valid bits cleared at that posedge; concurrent update discarded (invalidate wins); lookups from next cycle miss.
REQ-026 Tag/target/counter storage needs no reset; only valid bits are reset.

Reset
REQ-027 RST=1 at posedge clears all valid bits in one cycle; has priority over INVALIDATE and UPD_EN.
REQ-028 From the cycle after reset: PRED_TAKEN=0, PRED_TARGET=LKP_PC+4 for every PC.
REQ-029 Reset asserted mid-sequence discards any update presented in the same cycle.

Configuration
REQ-030 Macro OTTER_BTB_STATS_EN: when defined, adds outputs STAT_LOOKUPS, STAT_HITS, STAT_MISPRED (each 32 bits, input-free) and input LKP_VALID (1 bit).
REQ-031 With macro: STAT_LOOKUPS increments per cycle LKP_VALID=1; STAT_HITS per cycle LKP_VALID && hit; STAT_MISPRED per UPD_EN where stored prediction (pre-update) differs from UPD_TAKEN or, if predicted taken, stored target differs from UPD_TARGET; all wrap at 2^32, cleared by RST, not by INVALIDATE.
REQ-032 Without macro: those ports and counters absent; predictor behaviour identical.

Verification
REQ-033 Reset, then LKP_PC=0x100 -> PRED_TAKEN=0, PRED_TARGET=0x104.
REQ-034 Update PC=0x100 taken, target 0x40, conditional; next cycle LKP_PC=0x100 -> PRED_TAKEN=1, PRED_TARGET=0x40; ctr=10.
REQ-035 Two further not-taken updates to 0x100 -> after first PRED_TAKEN=0 (ctr 01), after second ctr 00; a third not-taken holds 00.
REQ-036 ENTRIES=16: entry for 0x100 valid, lookup 0x140 (same index, different tag) -> miss, PRED_TARGET=0x144; taken update 0x140 replaces entry, 0x100 then misses.
REQ-037 Update 0x200 and lookup 0x200 in same cycle -> lookup misses; next cycle hits. INVALIDATE with concurrent update -> all lookups miss next cycle.
REQ-038 OTTER_BTB_STATS_EN: 10 valid lookups with 4 hits, 3 updates with 1 wrong direction -> STAT_LOOKUPS=10, STAT_HITS=4, STAT_MISPRED=1; RST zeroes all three.

Source files
------------

// File: rtl/otter_btb_if.sv
// Lookup/update/invalidate bundle for otter_btb. Defining OTTER_BTB_STATS_EN
// adds the lookup-valid strobe and the three statistics counters.
interface otter_btb_if #(parameter int XLEN = 32);
  logic [XLEN-1:0] lkp_pc;
  logic            pred_taken;
  logic [XLEN-1:0] pred_target;
  logic            upd_en;
  logic [XLEN-1:0] upd_pc;
  logic            upd_taken;
  logic [XLEN-1:0] upd_target;
  logic            upd_jump;
  logic            invalidate;
`ifdef OTTER_BTB_STATS_EN
  logic            lkp_valid;
  logic [31:0]     stat_lookups;
  logic [31:0]     stat_hits;
  logic [31:0]     stat_mispred;

  modport master (output lkp_pc, upd_en, upd_pc, upd_taken, upd_target, upd_jump,
                         invalidate, lkp_valid,
                  input  pred_taken, pred_target, stat_lookups, stat_hits, stat_mispred);
  modport slave  (input  lkp_pc, upd_en, upd_pc, upd_taken, upd_target, upd_jump,
                         invalidate, lkp_valid,
                  output pred_taken, pred_target, stat_lookups, stat_hits, stat_mispred);
`else
  modport master (output lkp_pc, upd_en, upd_pc, upd_taken, upd_target, upd_jump,
                         invalidate,
                  input  pred_taken, pred_target);
  modport slave  (input  lkp_pc, upd_en, upd_pc, upd_taken, upd_target, upd_jump,
                         invalidate,
                  output pred_taken, pred_target);
`endif
endinterface

// File: rtl/otter_btb.sv
// Direct-mapped branch target buffer with 2-bit counters, zero-latency lookup.
// Optional statistics counters are compiled in with OTTER_BTB_STATS_EN.
module otter_btb_entry #(
  parameter int TAG_W = 26,
  parameter int XLEN  = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             inv_i,
  input  logic             we_i,
  input  logic [TAG_W-1:0] tag_i,
  input  logic [XLEN-1:0]  tgt_i,
  input  logic [1:0]       ctr_i,
  output logic             vld_o,
  output logic [TAG_W-1:0] tag_o,
  output logic [XLEN-1:0]  tgt_o,
  output logic [1:0]       ctr_o
);
  logic             vld_q;
  logic [TAG_W-1:0] tag_q;
  logic [XLEN-1:0]  tgt_q;
  logic [1:0]       ctr_q;

  always_ff @(posedge clk_i) begin
    if (rst_i || inv_i) vld_q <= 1'b0;
    else if (we_i)      vld_q <= 1'b1;
  end

  // Payload has no reset; the valid bit alone gates its use.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      tag_q <= tag_i;
      tgt_q <= tgt_i;
      ctr_q <= ctr_i;
    end
  end

  assign vld_o = vld_q;
  assign tag_o = tag_q;
  assign tgt_o = tgt_q;
  assign ctr_o = ctr_q;
endmodule

module otter_btb #(
  parameter int ENTRIES = 16,
  parameter int XLEN    = 32
) (
  input logic        clk_i,
  input logic        rst_i,
  otter_btb_if.slave bus
);
  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = XLEN - IDX_W - 2;

  logic [ENTRIES-1:0]            ent_vld;
  logic [ENTRIES-1:0][TAG_W-1:0] ent_tag;
  logic [ENTRIES-1:0][XLEN-1:0]  ent_tgt;
  logic [ENTRIES-1:0][1:0]       ent_ctr;
  logic [ENTRIES-1:0]            ent_we;

  logic [IDX_W-1:0] l_idx, u_idx;
  logic [TAG_W-1:0] l_tag, u_tag;
  logic             l_hit, u_hit, u_pred;
  logic             upd_we, wr_ok;
  logic [XLEN-1:0]  tgt_d;
  logic [1:0]       ctr_d;

  assign l_idx = bus.lkp_pc[IDX_W+1:2];
  assign l_tag = bus.lkp_pc[XLEN-1:IDX_W+2];
  assign u_idx = bus.upd_pc[IDX_W+1:2];
  assign u_tag = bus.upd_pc[XLEN-1:IDX_W+2];

  // Lookup reads registered state only, so a same-cycle update is not bypassed.
  assign l_hit           = ent_vld[l_idx] && (ent_tag[l_idx] == l_tag);
  assign bus.pred_taken  = l_hit && ent_ctr[l_idx][1];
  assign bus.pred_target = bus.pred_taken ? ent_tgt[l_idx] : bus.lkp_pc + XLEN'(4);

  assign u_hit  = ent_vld[u_idx] && (ent_tag[u_idx] == u_tag);
  assign u_pred = u_hit && ent_ctr[u_idx][1];

  always_comb begin
    upd_we = 1'b0;
    tgt_d  = ent_tgt[u_idx];
    ctr_d  = ent_ctr[u_idx];
    if (bus.upd_en) begin
      if (u_hit) begin
        upd_we = 1'b1;
        if (bus.upd_jump) begin
          ctr_d = 2'b11;
          tgt_d = bus.upd_target;
        end else if (bus.upd_taken) begin
          ctr_d = (ent_ctr[u_idx] == 2'b11) ? 2'b11 : ent_ctr[u_idx] + 2'd1;
          tgt_d = bus.upd_target;
        end else begin
          ctr_d = (ent_ctr[u_idx] == 2'b00) ? 2'b00 : ent_ctr[u_idx] - 2'd1;
        end
      end else if (bus.upd_taken || bus.upd_jump) begin
        upd_we = 1'b1;
        tgt_d  = bus.upd_target;
        ctr_d  = bus.upd_jump ? 2'b11 : 2'b10;
      end
    end
  end

  // Reset and invalidate both discard a concurrent update.
  assign wr_ok = upd_we && !rst_i && !bus.invalidate;

  for (genvar i = 0; i < ENTRIES; i++) begin : g_ent
    assign ent_we[i] = wr_ok && (u_idx == IDX_W'(i));
    otter_btb_entry #(.TAG_W(TAG_W), .XLEN(XLEN)) u_ent (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .inv_i (bus.invalidate),
      .we_i  (ent_we[i]),
      .tag_i (u_tag),
      .tgt_i (tgt_d),
      .ctr_i (ctr_d),
      .vld_o (ent_vld[i]),
      .tag_o (ent_tag[i]),
      .tgt_o (ent_tgt[i]),
      .ctr_o (ent_ctr[i])
    );
  end

`ifdef OTTER_BTB_STATS_EN
  logic [31:0] lookups_q, hits_q, mispred_q;
  logic        mispred;

  assign mispred = bus.upd_en &&
                   ((u_pred != bus.upd_taken) || (u_pred && ent_tgt[u_idx] != bus.upd_target));

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      lookups_q <= '0;
      hits_q    <= '0;
      mispred_q <= '0;
    end else begin
      lookups_q <= lookups_q + 32'(bus.lkp_valid);
      hits_q    <= hits_q + 32'(bus.lkp_valid && l_hit);
      mispred_q <= mispred_q + 32'(mispred);
    end
  end

  assign bus.stat_lookups = lookups_q;
  assign bus.stat_hits    = hits_q;
  assign bus.stat_mispred = mispred_q;
`else
  logic unused_pred;
  assign unused_pred = u_pred;
`endif

  logic unused_pc_lsb;
  assign unused_pc_lsb = ^{bus.lkp_pc[1:0], bus.upd_pc[1:0]};
endmodule

// File: tb/tb_otter_btb.sv
// Directed vector bench for otter_btb (ENTRIES=16, XLEN=32); the statistics
// sequence is compiled in with OTTER_BTB_STATS_EN.
module tb_otter_btb;
  logic clk = 1'b0;
  logic rst;
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  otter_btb_if #(.XLEN(32)) bus ();
  otter_btb #(.ENTRIES(16), .XLEN(32)) dut (.clk_i(clk), .rst_i(rst), .bus(bus));

  typedef struct {
    logic        ue;
    logic [31:0] upc;
    logic        ut;
    logic [31:0] utg;
    logic        uj;
    logic        inv;
    logic [31:0] lpc;
    logic        et;
    logic [31:0] etg;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(logic ue, logic [31:0] upc, logic ut, logic [31:0] utg,
                              logic uj, logic inv, logic [31:0] lpc, logic et,
                              logic [31:0] etg);
    vec_t v;
    v.ue = ue; v.upc = upc; v.ut = ut; v.utg = utg; v.uj = uj;
    v.inv = inv; v.lpc = lpc; v.et = et; v.etg = etg;
    vecs.push_back(v);
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s got=%h want=%h", nm, act, exp);
    end
  endtask

  task automatic drive(logic ue, logic [31:0] upc, logic ut, logic [31:0] utg,
                       logic uj, logic inv, logic [31:0] lpc);
    bus.upd_en = ue; bus.upd_pc = upc; bus.upd_taken = ut; bus.upd_target = utg;
    bus.upd_jump = uj; bus.invalidate = inv; bus.lkp_pc = lpc;
  endtask

  initial begin
    rst = 1'b1;
    drive(1'b0, '0, 1'b0, '0, 1'b0, 1'b0, 32'h100);
`ifdef OTTER_BTB_STATS_EN
    bus.lkp_valid = 1'b0;
`endif
    //  ue upc           ut utg           uj inv lpc           et  etg
    add(0, 32'h0,        0, 32'h0,        0, 0, 32'h100,       0, 32'h104);
    add(1, 32'h100,      1, 32'h40,       0, 0, 32'h100,       0, 32'h104);
    add(1, 32'h100,      0, 32'h0,        0, 0, 32'h100,       1, 32'h40);
    add(1, 32'h100,      0, 32'h0,        0, 0, 32'h100,       0, 32'h104);
    add(1, 32'h100,      0, 32'h0,        0, 0, 32'h100,       0, 32'h104);
    add(1, 32'h100,      1, 32'h40,       0, 0, 32'h100,       0, 32'h104);
    add(1, 32'h100,      1, 32'h40,       0, 0, 32'h100,       0, 32'h104);
    add(0, 32'h0,        0, 32'h0,        0, 0, 32'h100,       1, 32'h40);
    add(1, 32'h140,      1, 32'h80,       0, 0, 32'h140,       0, 32'h144);
    add(0, 32'h0,        0, 32'h0,        0, 0, 32'h140,       1, 32'h80);
    add(0, 32'h0,        0, 32'h0,        0, 0, 32'h100,       0, 32'h104);
    add(1, 32'h30C,      1, 32'h1000,     1, 0, 32'h30C,       0, 32'h310);
    add(1, 32'h30C,      0, 32'h0,        0, 0, 32'h30C,       1, 32'h1000);
    add(0, 32'h0,        0, 32'h0,        0, 0, 32'h30C,       1, 32'h1000);
    add(1, 32'h400,      0, 32'h44,       0, 0, 32'h400,       0, 32'h404);
    add(0, 32'h0,        0, 32'h0,        0, 0, 32'h140,       1, 32'h80);
    add(1, 32'h140,      1, 32'h90,       0, 0, 32'h140,       1, 32'h80);
    add(1, 32'h140,      0, 32'hDEAD0,    0, 0, 32'h140,       1, 32'h90);
    add(0, 32'h0,        0, 32'h0,        0, 0, 32'h140,       1, 32'h90);
    add(0, 32'h140,      1, 32'h55,       1, 0, 32'h140,       1, 32'h90);
    add(0, 32'h140,      0, 32'h55,       0, 0, 32'h140,       1, 32'h90);
    add(1, 32'h200,      1, 32'h20,       0, 0, 32'h200,       0, 32'h204);
    add(0, 32'h0,        0, 32'h0,        0, 0, 32'h200,       1, 32'h20);
    add(0, 32'h0,        0, 32'h0,        0, 0, 32'h202,       1, 32'h20);
    add(0, 32'h0,        0, 32'h0,        0, 0, 32'hFFFFFFFC,  0, 32'h0);
    add(1, 32'h500,      1, 32'h60,       0, 1, 32'h200,       1, 32'h20);
    add(0, 32'h0,        0, 32'h0,        0, 0, 32'h200,       0, 32'h204);
    add(0, 32'h0,        0, 32'h0,        0, 0, 32'h500,       0, 32'h504);
    add(0, 32'h0,        0, 32'h0,        0, 0, 32'h30C,       0, 32'h310);

    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    foreach (vecs[i]) begin
      drive(vecs[i].ue, vecs[i].upc, vecs[i].ut, vecs[i].utg, vecs[i].uj, vecs[i].inv,
            vecs[i].lpc);
      #2;
      chk($sformatf("v%0d taken", i), 32'(bus.pred_taken), 32'(vecs[i].et));
      chk($sformatf("v%0d target", i), bus.pred_target, vecs[i].etg);
      @(negedge clk);
    end

    // Reset in the middle of traffic drops the concurrent update.
    drive(1'b1, 32'h600, 1'b1, 32'h70, 1'b0, 1'b0, 32'h600);
    @(negedge clk);
    drive(1'b0, '0, 1'b0, '0, 1'b0, 1'b0, 32'h600);
    #2;
    chk("rst pre hit", 32'(bus.pred_taken), 32'h1);
    chk("rst pre tgt", bus.pred_target, 32'h70);
    @(negedge clk);
    rst = 1'b1;
    drive(1'b1, 32'h784, 1'b1, 32'h74, 1'b1, 1'b0, 32'h600);
    @(negedge clk);
    rst = 1'b0;
    drive(1'b0, '0, 1'b0, '0, 1'b0, 1'b0, 32'h600);
    #2;
    chk("rst clr taken", 32'(bus.pred_taken), 32'h0);
    chk("rst clr tgt", bus.pred_target, 32'h604);
    bus.lkp_pc = 32'h784;
    #2;
    chk("rst drop upd", 32'(bus.pred_taken), 32'h0);
    chk("rst drop tgt", bus.pred_target, 32'h788);

`ifdef OTTER_BTB_STATS_EN
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #2;
    chk("stat rst lkp", bus.stat_lookups, 32'd0);
    chk("stat rst mis", bus.stat_mispred, 32'd0);
    @(negedge clk);
    // Miss predicted not-taken, resolved taken: the one misprediction.
    drive(1'b1, 32'h800, 1'b1, 32'h10, 1'b0, 1'b0, 32'h800);
    @(negedge clk);
    drive(1'b0, '0, 1'b0, '0, 1'b0, 1'b0, 32'h800);
    bus.lkp_valid = 1'b1;
    for (int k = 0; k < 10; k++) begin
      bus.lkp_pc = (k < 4) ? 32'h800 : 32'h900;
      @(negedge clk);
    end
    bus.lkp_valid = 1'b0;
    repeat (2) begin
      drive(1'b1, 32'h800, 1'b1, 32'h10, 1'b0, 1'b0, 32'h900);
      @(negedge clk);
    end
    drive(1'b0, '0, 1'b0, '0, 1'b0, 1'b0, 32'h900);
    #2;
    chk("stat lookups", bus.stat_lookups, 32'd10);
    chk("stat hits", bus.stat_hits, 32'd4);
    chk("stat mispred", bus.stat_mispred, 32'd1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #2;
    chk("stat clr lkp", bus.stat_lookups, 32'd0);
    chk("stat clr hit", bus.stat_hits, 32'd0);
    chk("stat clr mis", bus.stat_mispred, 32'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
